// File: rtl/gate_stim_seq_if.sv
// gate_stim_seq_if: run control, AND-gate operands/results and status for the stimulus sequencer
interface gate_stim_seq_if;
    logic       start, abort, a, b, c1, c2, busy, done;
    logic [1:0] vec_idx;
    logic [7:0] err_cnt;
    modport master(output start, abort, c1, c2, input a, b, busy, done, vec_idx, err_cnt);
    modport slave(input start, abort, c1, c2, output a, b, busy, done, vec_idx, err_cnt);
endinterface

// File: rtl/gate_stim_seq.sv
// gate_stim_seq: drives Gray-ordered AND vectors and counts mismatching gate responses
module gate_stim_seq #(
    parameter int HOLD_CYCLES = 1,
    parameter int LOOPS       = 1
) (
    input logic           clk,
    input logic           rst,
    gate_stim_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, FIN} state_t;
    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] hold_q, hold_d, loop_q, loop_d, err_q, err_d;
    logic       a_w, b_w, mism;
    assign a_w = vec_q[1] ^ vec_q[0];
    assign b_w = vec_q[1];
    assign mism = (bus.c1 != (a_w & b_w)) || (bus.c2 != (a_w & b_w));
    assign bus.a = a_w;
    assign bus.b = b_w;
    assign bus.vec_idx = vec_q;
    assign bus.err_cnt = err_q;
    assign bus.busy = state_q == DRIVE;
    assign bus.done = state_q == FIN;
    // next-state: vector stepping, hold/loop counting, saturating error count
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        loop_d  = loop_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.start && !bus.abort) begin
                state_d = DRIVE;
                vec_d   = '0;
                hold_d  = '0;
                loop_d  = '0;
                err_d   = '0;
            end
            DRIVE: if (bus.abort) begin
                state_d = IDLE;
                vec_d   = '0;
                hold_d  = '0;
                loop_d  = '0;
            end else if (hold_q == 8'(HOLD_CYCLES - 1)) begin
                err_d  = (mism && err_q != 8'hff) ? err_q + 8'd1 : err_q;
                hold_d = '0;
                vec_d  = vec_q + 2'd1;
                if (vec_q == 2'd3) begin
                    state_d = (loop_q == 8'(LOOPS - 1)) ? FIN : DRIVE;
                    loop_d  = loop_q + 8'd1;
                end
            end else begin
                hold_d = hold_q + 8'd1;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state register with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            loop_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            loop_q  <= loop_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/gate_stim_seq.md
GATE_STIM_SEQ -- requirements
Module: gate_stim_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 1: clock cycles each input vector is held; legal range 1..255.
REQ-002 Parameter LOOPS, default 1: number of full 4-vector passes per run; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 abort  input  1  terminate run; returns to IDLE.
REQ-007 a  output  1  operand a to the downstream AND gate block, registered.
REQ-008 b  output  1  operand b to the downstream AND gate block, registered.
REQ-009 c1  input  1  first AND result returned from the gate block.
REQ-010 c2  input  1  second AND result returned from the gate block.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  one-cycle pulse on normal run completion.
REQ-013 vec_idx  output  2  index 0..3 of the vector currently driven.
REQ-014 err_cnt  output  8  count of mismatching vectors in the current or last run.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE and FIN.
REQ-016 Vector order SHALL be index 0:(a,b)=(0,0), 1:(1,0), 2:(1,1), 3:(0,1), i.e. Gray order.
REQ-017 IDLE with start=1 and abort=0 SHALL move to DRIVE at the next edge, with a,b=0,0, vec_idx=0, busy=1, err_cnt cleared to 0, hold and loop counters cleared.
REQ-018 In DRIVE, each vector SHALL be held exactly HOLD_CYCLES cycles.
REQ-019 On the final hold cycle of each vector, the block SHALL compare c1 and c2 against expected a&b using the currently driven a,b.
REQ-020 A vector with c1≠a&b or c2≠a&b SHALL add exactly 1 to err_cnt, regardless of whether one or both outputs mismatch.
REQ-021 err_cnt SHALL saturate at 255.
REQ-022 After vector 3, vec_idx SHALL wrap to 0 and the loop counter SHALL increment.
REQ-023 After the last vector of pass LOOPS, the FSM SHALL enter FIN for exactly one cycle with done=1, busy=0, a,b=0,0, then return to IDLE.
REQ-024 Total busy duration SHALL be 4*HOLD_CYCLES*LOOPS cycles.
REQ-025 start SHALL be ignored in DRIVE and FIN.
REQ-026 abort=1 in DRIVE SHALL force IDLE at the next edge with busy=0, a,b=0,0, vec_idx=0 and done never asserted; err_cnt keeps the value accumulated so far, and the compare in that cycle is discarded.
REQ-027 When start and abort are both 1 in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-028 In IDLE, outputs SHALL be a,b=0,0, vec_idx=0, busy=0, done=0, and err_cnt SHALL hold its last value.
REQ-029 done SHALL never be high in the same cycle as busy.

Reset
REQ-030 rst=1 SHALL, at the next edge and with priority over start and abort, force IDLE with a=0, b=0, vec_idx=0, busy=0, done=0, err_cnt=0, and all counters cleared, including when asserted mid-run.

Verification
REQ-031 Defaults with an ideal AND model and a start pulse -> a,b sequence 00,10,11,01 on consecutive cycles; busy high for 4 cycles; done pulses on cycle 5; err_cnt=0.
REQ-032 HOLD_CYCLES=3, LOOPS=2, ideal model -> each vector is stable for 3 cycles; busy lasts 24 cycles; exactly one done pulse.
REQ-033 c2 stuck at 1 (c1 correct) -> err_cnt=3 after one pass; c2 and c1 both stuck at 1 -> still 3.
REQ-034 Abort on the cycle where vec_idx=2 -> next cycle is IDLE with a,b=0,0 and no done pulse; err_cnt keeps its prior value; start with abort high -> no run starts.
REQ-035 rst pulsed mid-run with c1 stuck at 0 and err_cnt=1 -> the next cycle shows all outputs zero and err_cnt=0; a subsequent start runs normally.
REQ-036 LOOPS=255, HOLD_CYCLES=1, c1 always inverted -> err_cnt saturates at 255 and does not wrap.
